// File: rtl/mem_pkg.sv
// Shared types and codes for the scratch-memory request sequencer.
// Holds the FSM state enum, response status codes and expected debug codes.
package mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CAPTURE,
        S_RESP,
        S_VDRIVE,
        S_VWAIT
    } state_e;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_RANGE  = 2'b01;
    localparam logic [1:0] ST_DEBUG  = 2'b10;
    localparam logic [1:0] ST_VERIFY = 2'b11;

    localparam logic [1:0] DBG_WRITE = 2'b01;
    localparam logic [1:0] DBG_READ  = 2'b10;

    function automatic logic [1:0] exp_debug(input logic wr);
        return wr ? DBG_WRITE : DBG_READ;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_settle_timer.sv
// settle_timer: load/count/done down-counter timing memory settle windows.
// Ports: clk, rst (sync, active-high), load (preset to CYCLES-1),
//        en (decrement while nonzero), done (count is zero).
module settle_timer #(
    parameter int unsigned CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences read/write commands into the 8-bit scratch memory,
// holds its inputs for a settle window, captures out/debug and returns a response.
// Ports: clk, rst (sync, active-high); req_* command handshake; rsp_* response
//        handshake with 2-bit status; mem_* memory drive/observe; op_count.
// Optional: define MEM_ACCESS_CTRL_WRITE_VERIFY_EN to read back every write.
import mem_pkg::*;

module mem_access_ctrl #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [1:0]    rsp_status,
    output logic          mem_set,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_value,
    input  logic [DW-1:0] mem_out,
    input  logic [1:0]    mem_debug,
    output logic [7:0]    op_count
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_status_q, rsp_status_d;
    logic          mem_set_q, mem_set_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_value_q, mem_value_d;
    logic [7:0]    op_count_q, op_count_d;
    logic          wr_q, wr_d;

    logic accept;
    logic oor;
    logic hs;
    logic tmr_load;
    logic tmr_en;
    logic tmr_done;

    assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;
    assign oor    = ({1'b0, req_addr} >= DEPTH_W);
    assign hs     = rsp_valid_q && rsp_ready;

    // The timer starts at accept so DRIVE counts as the first settle cycle.
    assign tmr_load = (accept && !oor) || (state_q == S_VDRIVE);
    assign tmr_en   = (state_q == S_DRIVE) || (state_q == S_WAIT)
                   || (state_q == S_VWAIT);

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .en   (tmr_en),
        .done (tmr_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = oor ? S_RESP : S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = tmr_done ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (tmr_done) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
                state_d = wr_q ? S_VDRIVE : S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
            S_VDRIVE: begin
                state_d = S_VWAIT;
            end
            S_VWAIT: begin
                if (tmr_done) begin
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        mem_set_d     = mem_set_q;
        mem_address_d = mem_address_q;
        mem_value_d   = mem_value_q;
        op_count_d    = op_count_q;
        wr_d          = wr_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                mem_set_d   = 1'b0;
                if (accept) begin
                    req_ready_d = 1'b0;
                    wr_d        = req_write;
                    if (oor) begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_RANGE;
                    end else begin
                        mem_set_d     = req_write;
                        mem_address_d = req_addr;
                        mem_value_d   = req_data;
                    end
                end
            end
            S_CAPTURE: begin
                // mem_out is sampled while the inputs are still held
                mem_set_d  = 1'b0;
                rsp_data_d = mem_out;
                if (mem_debug != exp_debug(wr_q)) begin
                    rsp_status_d = ST_DEBUG;
                end else begin
                    rsp_status_d = ST_OK;
                end
            end
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
            S_VWAIT: begin
                // mem_value_q still holds the write data for the compare
                if (tmr_done && (mem_out != mem_value_q)) begin
                    rsp_data_d = mem_out;
                    if (rsp_status_q != ST_DEBUG) begin
                        rsp_status_d = ST_VERIFY;
                    end
                end
            end
`endif
            S_RESP: begin
                rsp_valid_d = 1'b1;
                if (hs) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    op_count_d  = op_count_q + 8'd1;
                end
            end
            default: begin
                req_ready_d = 1'b0;
            end
        endcase
    end

    // Output and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= ST_OK;
            mem_set_q     <= 1'b0;
            mem_address_q <= '0;
            mem_value_q   <= '0;
            op_count_q    <= '0;
            wr_q          <= 1'b0;
        end else begin
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            mem_set_q     <= mem_set_d;
            mem_address_q <= mem_address_d;
            mem_value_q   <= mem_value_d;
            op_count_q    <= op_count_d;
            wr_q          <= wr_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign mem_set     = mem_set_q;
    assign mem_address = mem_address_q;
    assign mem_value   = mem_value_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 8-entry scratch memory.
// Memory faults (debug forced to 00, dropped writes) are injected via flags.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    localparam int WLAT = 7;
`else
    localparam int WLAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic       mem_set;
    logic [7:0] mem_address;
    logic [7:0] mem_value;
    logic [7:0] mem_out;
    logic [1:0] mem_debug;
    logic [7:0] op_count;

    logic       mem_init;
    logic       force_dbg0;
    logic       drop_write;
    logic [7:0] mem [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .mem_set     (mem_set),
        .mem_address (mem_address),
        .mem_value   (mem_value),
        .mem_out     (mem_out),
        .mem_debug   (mem_debug),
        .op_count    (op_count)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            mem_out   <= 8'h00;
            mem_debug <= 2'b00;
        end else if (mem_set) begin
            if (!drop_write) mem[mem_address[2:0]] <= mem_value;
            mem_out   <= mem_value;
            mem_debug <= force_dbg0 ? 2'b00 : 2'b01;
        end else begin
            mem_out   <= mem[mem_address[2:0]];
            mem_debug <= force_dbg0 ? 2'b00 : 2'b10;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command; return edges from accept to rsp_valid, number of
    // sampled cycles with mem_set high, and whether mem_address moved.
    task automatic run_cmd(input logic w, input logic [7:0] a,
                           input logic [7:0] d, output int lat,
                           output int nset, output logic moved);
        logic [7:0] a0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = a + 8'd1;
        req_data  = ~d;
        lat   = 0;
        nset  = int'(mem_set);
        moved = 1'b0;
        a0    = mem_address;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
            nset += int'(mem_set);
            if (mem_address !== a0) moved = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        int   nset;
        int   bad;
        int   seen;
        logic moved;
        logic [7:0] iv;

        rst        = 1'b1;
        mem_init   = 1'b1;
        force_dbg0 = 1'b0;
        drop_write = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 8'h00;
        req_data   = 8'h00;
        rsp_ready  = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_mem_set", mem_set, 0);
        rst      = 1'b0;
        mem_init = 1'b0;
        tick();
        chk("idle_req_ready", req_ready, 1);

        // Write 3 <- A5
        run_cmd(1'b1, 8'h03, 8'hA5, lat, nset, moved);
        chk("wr_lat", lat, WLAT);
        chk("wr_nset", nset, 3);
        chk("wr_data", rsp_data, 8'hA5);
        chk("wr_status", rsp_status, 2'b00);
        chk("wr_req_ready", req_ready, 0);
        tick();
        chk("wr_valid_drop", rsp_valid, 0);
        chk("wr_op_count", op_count, 1);
        chk("wr_ready_back", req_ready, 1);

        // Read 3
        run_cmd(1'b0, 8'h03, 8'h00, lat, nset, moved);
        chk("rd_lat", lat, 4);
        chk("rd_nset", nset, 0);
        chk("rd_addr_stable", moved, 0);
        chk("rd_addr", mem_address, 8'h03);
        chk("rd_data", rsp_data, 8'hA5);
        chk("rd_status", rsp_status, 2'b00);
        tick();
        chk("rd_op_count", op_count, 2);

        // Read 8: out of range
        run_cmd(1'b0, 8'h08, 8'h00, lat, nset, moved);
        chk("oor_lat", lat, 1);
        chk("oor_status", rsp_status, 2'b01);
        chk("oor_data", rsp_data, 8'h00);
        chk("oor_nset", nset, 0);
        chk("oor_addr", mem_address, 8'h03);
        tick();
        chk("oor_op_count", op_count, 3);

        // Back-pressure with a stray request pulse
        rsp_ready = 1'b0;
        run_cmd(1'b0, 8'h03, 8'h00, lat, nset, moved);
        chk("bp_lat", lat, 4);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 8'h05;
                req_data  = 8'h77;
            end
            tick();
            req_valid = 1'b0;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'hA5);
            chk("bp_status", rsp_status, 2'b00);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_valid_drop", rsp_valid, 0);
        chk("bp_op_count", op_count, 4);
        tick();
        chk("bp_no_accept", mem_set, 0);
        chk("bp_idle_ready", req_ready, 1);

        // Debug code forced to 00 on a read
        force_dbg0 = 1'b1;
        run_cmd(1'b0, 8'h03, 8'h00, lat, nset, moved);
        chk("dbg_status", rsp_status, 2'b10);
        chk("dbg_data", rsp_data, 8'hA5);
        force_dbg0 = 1'b0;
        tick();

        // Address 5 must be untouched by the stray pulse
        run_cmd(1'b0, 8'h05, 8'h00, lat, nset, moved);
        chk("stray_data", rsp_data, 8'h00);
        chk("stray_status", rsp_status, 2'b00);
        tick();
        chk("stray_op_count", op_count, 6);

        // Write 2 <- 11, then a dropped write of 3C
        run_cmd(1'b1, 8'h02, 8'h11, lat, nset, moved);
        chk("w2_status", rsp_status, 2'b00);
        tick();
        drop_write = 1'b1;
        run_cmd(1'b1, 8'h02, 8'h3C, lat, nset, moved);
        drop_write = 1'b0;
        chk("drop_lat", lat, WLAT);
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
        chk("drop_status", rsp_status, 2'b11);
        chk("drop_data", rsp_data, 8'h11);
`else
        chk("drop_status", rsp_status, 2'b00);
        chk("drop_data", rsp_data, 8'h3C);
`endif
        tick();
        run_cmd(1'b0, 8'h02, 8'h00, lat, nset, moved);
        chk("r2_data", rsp_data, 8'h11);
        tick();
        chk("r2_op_count", op_count, 9);

        // Reset during WAIT of a write
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h04;
        req_data  = 8'h99;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_set", mem_set, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_req_ready", req_ready, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_rsp_data", rsp_data, 0);
        chk("mr_rsp_status", rsp_status, 0);
        chk("mr_mem_set", mem_set, 0);
        chk("mr_mem_address", mem_address, 0);
        chk("mr_mem_value", mem_value, 0);
        chk("mr_op_count", op_count, 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen += int'(rsp_valid);
        end
        chk("mr_no_rsp", seen, 0);
        chk("mr_ready", req_ready, 1);

        // 256 good transactions wrap op_count
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            run_cmd(iv[0], {5'b0, iv[2:0]}, iv, lat, nset, moved);
            if (lat >= 40 || rsp_status !== 2'b00) bad++;
            tick();
            if (i == 254) chk("cnt_255", op_count, 255);
        end
        chk("loop_bad", bad, 0);
        chk("cnt_wrap", op_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
